// File: rtl/qbert_display_timing_if.sv
// Raster timing bundle from qbert_display_timing to the map renderer and cube generators.
// frame_cnt is present only when QBERT_FRAMECNT_EN is defined.
interface qbert_display_timing_if;
    logic [10:0] x_cnt;
    logic [9:0]  y_cnt;
    logic        frame_start;
    logic        line_start;
    logic        hsync_n;
    logic        vsync_n;
    logic        de;
`ifdef QBERT_FRAMECNT_EN
    logic [15:0] frame_cnt;
`endif

    modport master (
        output x_cnt, y_cnt, frame_start, line_start, hsync_n, vsync_n, de
`ifdef QBERT_FRAMECNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input x_cnt, y_cnt, frame_start, line_start, hsync_n, vsync_n, de
`ifdef QBERT_FRAMECNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/qbert_display_timing.sv
// Free-running raster timing generator; sync/de strobes are delayed PIPE_DLY cycles to match renderer RGB.
// Optional completed-frame counter enabled by defining QBERT_FRAMECNT_EN.
module qbert_display_timing #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 210,
    parameter int H_SYNC   = 30,
    parameter int H_BP     = 16,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 22,
    parameter int V_SYNC   = 13,
    parameter int V_BP     = 10,
    parameter int PIPE_DLY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    qbert_display_timing_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] X_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] X_ACT_END  = 11'(H_ACTIVE);
    localparam logic [10:0] X_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] X_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  Y_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  Y_ACT_END  = 10'(V_ACTIVE);
    localparam logic [9:0]  Y_SYNC_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  Y_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word is {hsync_n, vsync_n, de}; idle means syncs high, de low.
    localparam logic [2:0] IDLE = 3'b110;

    logic [10:0] x_q;
    logic [9:0]  y_q;
    logic        de_raw;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  raw_bus;
    logic [2:0]  out_bus;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else if (x_q == X_LAST) begin
            x_q <= '0;
            y_q <= (y_q == Y_LAST) ? '0 : y_q + 10'd1;
        end else begin
            x_q <= x_q + 11'd1;
        end
    end

    always_comb begin
        de_raw  = (x_q < X_ACT_END) && (y_q < Y_ACT_END);
        hs_raw  = (x_q >= X_SYNC_BEG) && (x_q < X_SYNC_END);
        vs_raw  = (y_q >= Y_SYNC_BEG) && (y_q < Y_SYNC_END);
        raw_bus = {~hs_raw, ~vs_raw, de_raw};
    end

    if (PIPE_DLY == 0) begin : g_no_dly
        assign out_bus = raw_bus;
    end else begin : g_dly
        logic [2:0] pipe_q [PIPE_DLY];

        // Reset flushes every stage so no pre-reset strobe can emerge afterwards.
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < PIPE_DLY; i++) pipe_q[i] <= IDLE;
            end else begin
                pipe_q[0] <= raw_bus;
                for (int i = 1; i < PIPE_DLY; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end

        assign out_bus = pipe_q[PIPE_DLY-1];
    end

`ifdef QBERT_FRAMECNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_cnt_q <= '0;
        end else if (x_q == X_LAST && y_q == Y_LAST) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vid.frame_cnt = frame_cnt_q;
`endif

    assign vid.x_cnt       = x_q;
    assign vid.y_cnt       = y_q;
    assign vid.frame_start = (x_q == '0) && (y_q == '0);
    assign vid.line_start  = (x_q == '0);
    assign vid.hsync_n     = out_bus[2];
    assign vid.vsync_n     = out_bus[1];
    assign vid.de          = out_bus[0];
endmodule

// File: tb/tb_qbert_display_timing.sv
// Bench for qbert_display_timing: reduced raster, one PIPE_DLY=2 and one PIPE_DLY=0 instance,
// checked against an arithmetic model driven by the cycle count since reset.
module tb_qbert_display_timing;
    localparam int HA = 40, HFP = 10, HS = 6, HB = 4;
    localparam int VA = 20, VFP = 3,  VS = 2, VB = 2;
    localparam int HT = HA + HFP + HS + HB;
    localparam int VT = VA + VFP + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int D = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qbert_display_timing_if vid2 ();
    qbert_display_timing_if vid0 ();

    qbert_display_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(D)
    ) u_dut (
        .clk(clk), .reset(rst), .vid(vid2)
    );

    qbert_display_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VB), .PIPE_DLY(0)
    ) u_dut0 (
        .clk(clk), .reset(rst), .vid(vid0)
    );

    int n_cmp = 0;
    int n_err = 0;

    // ---------------- reference model ----------------
    // Position is cycles since reset modulo the raster; strobes come from a history queue.
    int          m_t;
    int          m_x;
    int          m_y;
    logic [15:0] m_fc;
    logic [15:0] fc_ofs = 16'd0;
    logic [2:0]  exp_q[$];
    logic [2:0]  e2;
    logic [2:0]  e0;

    function automatic logic [2:0] decode(int x, int y);
        logic h, v, a;
        a = (x < HA) && (y < VA);
        h = (x >= HA + HFP) && (x < HA + HFP + HS);
        v = (y >= VA + VFP) && (y < VA + VFP + VS);
        return {~h, ~v, a};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_t  = 0;
            m_fc = 16'd0;
            exp_q.delete();
        end else begin
            m_t = m_t + 1;
            if (m_t % FRAME == 0) m_fc = m_fc + 16'd1;
        end
        m_x = m_t % HT;
        m_y = (m_t / HT) % VT;
        exp_q.push_back(decode(m_x, m_y));
        if (exp_q.size() > 8) void'(exp_q.pop_front());
        e0 = exp_q[exp_q.size()-1];
        e2 = (exp_q.size() > D) ? exp_q[exp_q.size()-1-D] : 3'b110;
    end

    function automatic logic [25:0] exp_vec(logic [2:0] strobes);
        return {11'(m_x), 10'(m_y), (m_x == 0 && m_y == 0), (m_x == 0), strobes};
    endfunction

    function automatic logic [25:0] act_vec2();
        return {vid2.x_cnt, vid2.y_cnt, vid2.frame_start, vid2.line_start,
                vid2.hsync_n, vid2.vsync_n, vid2.de};
    endfunction

    function automatic logic [25:0] act_vec0();
        return {vid0.x_cnt, vid0.y_cnt, vid0.frame_start, vid0.line_start,
                vid0.hsync_n, vid0.vsync_n, vid0.de};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset(int cycles);
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vid2.x_cnt, vid2.y_cnt, vid2.hsync_n, vid2.vsync_n, vid2.de} !== {11'd0, 10'd0, 3'b110}) begin
                n_err++;
                $display("FAIL reset_hold cyc=%0d got x=%0d y=%0d hs=%b vs=%b de=%b want 0 0 1 1 0",
                         i, vid2.x_cnt, vid2.y_cnt, vid2.hsync_n, vid2.vsync_n, vid2.de);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({vid2.x_cnt, vid2.de} !== {11'(n), (n >= D)}) begin
                n_err++;
                $display("FAIL reset_release n=%0d got x=%0d de=%b want x=%0d de=%b",
                         n, vid2.x_cnt, vid2.de, n, (n >= D));
            end
        end
    endtask

    task automatic test_line();
        int hs_low = 0, de_hi = 0, run = 0, max_run = 0;
        bit seen = 0;
        do_reset(1);
        for (int i = 0; i < HT + D; i++) begin
            if (i > 0) @(negedge clk);
            if (!vid2.hsync_n) begin
                hs_low++;
                if (!seen) begin
                    seen = 1;
                    n_cmp++;
                    if (vid2.x_cnt !== 11'(HA + HFP + D)) begin
                        n_err++;
                        $display("FAIL hsync_first_low got x=%0d want %0d", vid2.x_cnt, HA + HFP + D);
                    end
                end
            end
            if (vid2.de) begin
                de_hi++;
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        n_cmp++;
        if (hs_low !== HS) begin
            n_err++;
            $display("FAIL hsync_width got %0d want %0d", hs_low, HS);
        end
        n_cmp++;
        if ({de_hi, max_run} !== {HA, HA}) begin
            n_err++;
            $display("FAIL de_line got total=%0d run=%0d want %0d consecutive", de_hi, max_run, HA);
        end
    endtask

    task automatic test_frames();
        int last_fs = -1, de_cnt = 0, vs_low = 0;
        bit vs_seen = 0;
        do_reset(1);
        for (int n = 0; n < 2 * FRAME + D; n++) begin
            if (n > 0) @(negedge clk);
            n_cmp++;
            if (act_vec2() !== exp_vec(e2)) begin
                n_err++;
                $display("FAIL frame_run_dly n=%0d got %h want %h", n, act_vec2(), exp_vec(e2));
            end
            if (vid2.frame_start) begin
                if (last_fs >= 0) begin
                    n_cmp++;
                    if (n - last_fs !== FRAME) begin
                        n_err++;
                        $display("FAIL frame_spacing got %0d want %0d", n - last_fs, FRAME);
                    end
                end
                last_fs = n;
            end
            if (vid2.de) de_cnt++;
            if (!vid2.vsync_n) begin
                vs_low++;
                if (!vs_seen) begin
                    vs_seen = 1;
                    n_cmp++;
                    if ({vid2.x_cnt, vid2.y_cnt} !== {11'(D), 10'(VA + VFP)}) begin
                        n_err++;
                        $display("FAIL vsync_first_low got x=%0d y=%0d want %0d %0d",
                                 vid2.x_cnt, vid2.y_cnt, D, VA + VFP);
                    end
                end
            end
        end
        n_cmp++;
        if (de_cnt !== 2 * HA * VA) begin
            n_err++;
            $display("FAIL de_per_frame got %0d want %0d", de_cnt, 2 * HA * VA);
        end
        n_cmp++;
        if (vs_low !== 2 * VS * HT) begin
            n_err++;
            $display("FAIL vsync_per_frame got %0d want %0d", vs_low, 2 * VS * HT);
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        repeat (10 * HT + 25) @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({vid2.x_cnt, vid2.y_cnt, vid2.hsync_n, vid2.vsync_n, vid2.de} !== {11'd0, 10'd0, 3'b110}) begin
                n_err++;
                $display("FAIL mid_reset_hold got x=%0d y=%0d hs=%b vs=%b de=%b want 0 0 1 1 0",
                         vid2.x_cnt, vid2.y_cnt, vid2.hsync_n, vid2.vsync_n, vid2.de);
            end
        end
        rst = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(negedge clk);
            n_cmp++;
            if ({vid2.hsync_n, vid2.vsync_n, vid2.de} !== {2'b11, (n >= D)}) begin
                n_err++;
                $display("FAIL mid_reset_release n=%0d got hs=%b vs=%b de=%b want 1 1 %b",
                         n, vid2.hsync_n, vid2.vsync_n, vid2.de, (n >= D));
            end
        end
    endtask

    task automatic test_pipe0();
        do_reset(1);
        for (int n = 0; n < 2 * HT; n++) begin
            if (n > 0) @(negedge clk);
            n_cmp++;
            if (act_vec0() !== exp_vec(e0)) begin
                n_err++;
                $display("FAIL pipe0_run n=%0d got %h want %h", n, act_vec0(), exp_vec(e0));
            end
            if (vid0.x_cnt == 11'(HA) || vid0.x_cnt == 11'(HA + HFP) || vid0.x_cnt == 11'(HA + HFP + HS)) begin
                n_cmp++;
                if ({vid0.hsync_n, vid0.de} !== {(vid0.x_cnt != 11'(HA + HFP)), 1'b0}) begin
                    n_err++;
                    $display("FAIL pipe0_boundary x=%0d got hs=%b de=%b want hs=%b de=0", vid0.x_cnt,
                             vid0.hsync_n, vid0.de, (vid0.x_cnt != 11'(HA + HFP)));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            if ($urandom_range(0, 2) == 0) do_reset($urandom_range(1, 3));
            repeat ($urandom_range(50, 600)) begin
                @(negedge clk);
                n_cmp++;
                if (act_vec2() !== exp_vec(e2)) begin
                    n_err++;
                    $display("FAIL random_dly t=%0d got %h want %h", m_t, act_vec2(), exp_vec(e2));
                end
                n_cmp++;
                if (act_vec0() !== exp_vec(e0)) begin
                    n_err++;
                    $display("FAIL random_pipe0 t=%0d got %h want %h", m_t, act_vec0(), exp_vec(e0));
                end
            end
        end
    endtask

`ifdef QBERT_FRAMECNT_EN
    task automatic test_frame_cnt();
        do_reset(1);
        n_cmp++;
        if (vid2.frame_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL frame_cnt_reset got %h want 0000", vid2.frame_cnt);
        end
        force u_dut.frame_cnt_q = 16'hFFFF;
        release u_dut.frame_cnt_q;
        fc_ofs = 16'hFFFF;
        for (int f = 1; f <= 2; f++) begin
            repeat (FRAME) @(negedge clk);
            n_cmp++;
            if (vid2.frame_cnt !== 16'(m_fc + fc_ofs)) begin
                n_err++;
                $display("FAIL frame_cnt_wrap f=%0d got %h want %h", f, vid2.frame_cnt, 16'(m_fc + fc_ofs));
            end
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_mid_reset();
        test_pipe0();
        test_random();
`ifdef QBERT_FRAMECNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
